// File: rtl/seg7_decoder.sv
// seg7_decoder: recovers per-digit hex values from a scanned active-low 7-segment bus
// Optional feature macro: SEG7_DP_EN (8-bit seg_in with decimal point, adds dp_out)
module seg7_decoder #(
   parameter int NUM_DIGITS    = 6,
   parameter int STABLE_CYCLES = 4,
   parameter int UPD_DEPTH     = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
`ifdef SEG7_DP_EN
   input  logic [7:0]              seg_in,
   output logic [NUM_DIGITS-1:0]   dp_out,
`else
   input  logic [6:0]              seg_in,
`endif
   input  logic [2:0]              dig_sel,
   input  logic                    seg_strobe,
   output logic [4*NUM_DIGITS-1:0] hex_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    upd_valid,
   input  logic                    upd_ready,
   output logic [2:0]              upd_digit,
   output logic [3:0]              upd_hex,
   output logic                    upd_err,
   output logic                    upd_overflow,
   output logic [7:0]              err_count
);
`ifdef SEG7_DP_EN
   localparam int SW = 8;
`else
   localparam int SW = 7;
`endif
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int AW = $clog2(UPD_DEPTH);
   localparam logic [CW-1:0] SC = CW'(STABLE_CYCLES);

   logic [2:0]              cand_dig_q, cand_dig_d;
   logic [SW-1:0]           cand_seg_q, cand_seg_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [SW-1:0]           pat_q [NUM_DIGITS];
   logic [SW-1:0]           pat_d [NUM_DIGITS];
   logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
   logic [NUM_DIGITS-1:0]   dv_q, dv_d;
   logic [NUM_DIGITS-1:0]   dp_q, dp_d;
   logic [7:0]              err_q, err_d;
   logic                    ovf_q, ovf_d;
   logic [7:0]              mem_q [UPD_DEPTH];
   logic [7:0]              mem_d [UPD_DEPTH];
   logic [AW:0]             wr_q, wr_d, rd_q, rd_d;
   logic                    vs, match, commit, push, pop, full, wr_en;
   logic [4:0]              dec;
   logic [7:0]              push_word;

   // returns {legal, hex}; illegal patterns decode to hex 0
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h40: decode = 5'h10;
         7'h79: decode = 5'h11;
         7'h24: decode = 5'h12;
         7'h30: decode = 5'h13;
         7'h19: decode = 5'h14;
         7'h12: decode = 5'h15;
         7'h02: decode = 5'h16;
         7'h78: decode = 5'h17;
         7'h00: decode = 5'h18;
         7'h10: decode = 5'h19;
         7'h08: decode = 5'h1A;
         7'h03: decode = 5'h1B;
         7'h46: decode = 5'h1C;
         7'h21: decode = 5'h1D;
         7'h06: decode = 5'h1E;
         7'h0E: decode = 5'h1F;
         default: decode = 5'h00;
      endcase
   endfunction

   // candidate tracking, commit decision and per-digit committed state
   always_comb begin
      cand_dig_d = cand_dig_q;
      cand_seg_d = cand_seg_q;
      cnt_d      = cnt_q;
      pat_d      = pat_q;
      hex_d      = hex_q;
      dv_d       = dv_q;
      dp_d       = dp_q;
      err_d      = err_q;
      push       = 1'b0;
      vs         = seg_strobe && ({1'b0, dig_sel} < 4'(NUM_DIGITS));
      match      = (cand_dig_q == dig_sel) && (cand_seg_q == seg_in);
      commit     = vs && (match ? (cnt_q == SC - CW'(1)) : (STABLE_CYCLES == 1));
      dec        = decode(seg_in[6:0]);
      push_word  = {dig_sel, dec[3:0], ~dec[4]};
      if (vs) begin
         cand_dig_d = dig_sel;
         cand_seg_d = seg_in;
         cnt_d      = !match ? CW'(1) : (cnt_q == SC) ? cnt_q : cnt_q + CW'(1);
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (commit && dig_sel == 3'(i) && seg_in != pat_q[i]) begin
            pat_d[i] = seg_in;
            dv_d[i]  = dec[4];
            if (dec[4]) hex_d[4*i +: 4] = dec[3:0];
`ifdef SEG7_DP_EN
            dp_d[i]  = ~seg_in[7];
`endif
            push     = dec[4] || seg_in[6:0] != 7'h7F;
            if (!dec[4] && seg_in[6:0] != 7'h7F && err_q != 8'hFF) err_d = err_q + 8'd1;
         end
      end
   end

   // change-event FIFO: a push into a full FIFO survives only if the head pops on the same edge
   always_comb begin
      mem_d = mem_q;
      pop   = upd_valid && upd_ready;
      full  = (wr_q - rd_q) == (AW+1)'(UPD_DEPTH);
      wr_en = push && (!full || pop);
      ovf_d = ovf_q || (push && full && !pop);
      if (wr_en) mem_d[wr_q[AW-1:0]] = push_word;
      wr_d  = wr_q + (AW+1)'(wr_en);
      rd_d  = rd_q + (AW+1)'(pop);
   end

   // state registers, asynchronously cleared to blank/empty
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cand_dig_q <= '0;
         cand_seg_q <= '0;
         cnt_q      <= '0;
         pat_q      <= '{default: '1};
         hex_q      <= '0;
         dv_q       <= '0;
         dp_q       <= '0;
         err_q      <= '0;
         ovf_q      <= 1'b0;
         mem_q      <= '{default: '0};
         wr_q       <= '0;
         rd_q       <= '0;
      end else begin
         cand_dig_q <= cand_dig_d;
         cand_seg_q <= cand_seg_d;
         cnt_q      <= cnt_d;
         pat_q      <= pat_d;
         hex_q      <= hex_d;
         dv_q       <= dv_d;
         dp_q       <= dp_d;
         err_q      <= err_d;
         ovf_q      <= ovf_d;
         mem_q      <= mem_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
      end
   end

   assign hex_out      = hex_q;
   assign digit_valid  = dv_q;
   assign err_count    = err_q;
   assign upd_overflow = ovf_q;
   assign upd_valid    = wr_q != rd_q;
   assign {upd_digit, upd_hex, upd_err} = mem_q[rd_q[AW-1:0]];
`ifdef SEG7_DP_EN
   assign dp_out = dp_q;
`else
   logic unused_dp;
   assign unused_dp = ^dp_q;
`endif
endmodule

// File: tb/tb_seg7_decoder.sv
// tb_seg7_decoder: directed scoreboard bench for seg7_decoder (default build)
module tb_seg7_decoder;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [6:0]  seg_in = 7'h7F;
   logic [2:0]  dig_sel = 3'd0;
   logic        seg_strobe = 1'b0;
   logic [23:0] hex_out;
   logic [5:0]  digit_valid;
   logic        upd_valid;
   logic        upd_ready = 1'b0;
   logic [2:0]  upd_digit;
   logic [3:0]  upd_hex;
   logic        upd_err;
   logic        upd_overflow;
   logic [7:0]  err_count;

   int total = 0;
   int fails = 0;
   logic [7:0] sb [$];

   seg7_decoder dut (
      .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .dig_sel(dig_sel),
      .seg_strobe(seg_strobe), .hex_out(hex_out), .digit_valid(digit_valid),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_digit(upd_digit),
      .upd_hex(upd_hex), .upd_err(upd_err), .upd_overflow(upd_overflow),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic strobe(input logic [2:0] d, input logic [6:0] s, input int n);
      repeat (n) begin
         dig_sel = d;
         seg_in = s;
         seg_strobe = 1'b1;
         @(posedge clk);
         #1;
      end
      seg_strobe = 1'b0;
   endtask

   task automatic drain();
      while (sb.size() > 0) begin
         int k = 0;
         logic [7:0] e;
         while (!upd_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
         end
         chk("upd_valid_wait", upd_valid, 1);
         e = sb.pop_front();
         chk("upd_event", {upd_digit, upd_hex, upd_err}, e);
         upd_ready = 1'b1;
         @(posedge clk);
         #1;
         upd_ready = 1'b0;
      end
      chk("fifo_empty", upd_valid, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hex", hex_out, 0);
      chk("rst_dv", digit_valid, 0);
      chk("rst_upd_valid", upd_valid, 0);
      chk("rst_ovf", upd_overflow, 0);
      chk("rst_err", err_count, 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      strobe(3'd2, 7'h24, 4);
      sb.push_back({3'd2, 4'h2, 1'b0});
      chk("d2_hex", hex_out[11:8], 4'h2);
      chk("d2_dv", digit_valid[2], 1);
      chk("d2_upd_valid", upd_valid, 1);
      drain();

      strobe(3'd0, 7'h24, 2);
      strobe(3'd0, 7'h30, 4);
      sb.push_back({3'd0, 4'h3, 1'b0});
      chk("d0_hex", hex_out[3:0], 4'h3);
      drain();

      strobe(3'd1, 7'h00, 4);
      sb.push_back({3'd1, 4'h8, 1'b0});
      drain();
      strobe(3'd1, 7'h55, 4);
      sb.push_back({3'd1, 4'h0, 1'b1});
      chk("ill_hex_held", hex_out[7:4], 4'h8);
      chk("ill_dv", digit_valid[1], 0);
      chk("ill_err_count", err_count, 1);
      drain();

      strobe(3'd3, 7'h7F, 4);
      chk("noop_no_event", upd_valid, 0);
      strobe(3'd1, 7'h7F, 4);
      chk("blank_no_event", upd_valid, 0);
      chk("blank_hex_held", hex_out[7:4], 4'h8);
      chk("blank_dv", digit_valid[1], 0);
      chk("blank_err_count", err_count, 1);

      strobe(3'd0, 7'h19, 4);
      sb.push_back({3'd0, 4'h4, 1'b0});
      strobe(3'd1, 7'h12, 4);
      sb.push_back({3'd1, 4'h5, 1'b0});
      strobe(3'd2, 7'h02, 4);
      sb.push_back({3'd2, 4'h6, 1'b0});
      strobe(3'd3, 7'h78, 4);
      sb.push_back({3'd3, 4'h7, 1'b0});
      chk("pre_ovf", upd_overflow, 0);
      strobe(3'd4, 7'h10, 4);
      chk("ovf_set", upd_overflow, 1);
      chk("ovf_hex_all", hex_out, 24'h097654);
      chk("ovf_dv_all", digit_valid, 6'b011111);
      drain();
      chk("ovf_sticky", upd_overflow, 1);

      strobe(3'd5, 7'h79, 3);
      #3 reset_n = 1'b0;
      #1;
      chk("mid_rst_hex", hex_out, 0);
      chk("mid_rst_dv", digit_valid, 0);
      chk("mid_rst_ovf", upd_overflow, 0);
      chk("mid_rst_err", err_count, 0);
      chk("mid_rst_upd_valid", upd_valid, 0);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;
      strobe(3'd5, 7'h79, 3);
      chk("post_rst_3_no_commit", digit_valid[5], 0);
      strobe(3'd5, 7'h79, 1);
      sb.push_back({3'd5, 4'h1, 1'b0});
      chk("post_rst_dv", digit_valid[5], 1);
      chk("post_rst_hex", hex_out[23:20], 4'h1);
      drain();

      strobe(3'd4, 7'h40, 3);
      strobe(3'd6, 7'h40, 10);
      chk("bad_sel_no_event", upd_valid, 0);
      chk("bad_sel_hex", hex_out, 24'h100000);
      chk("bad_sel_dv", digit_valid, 6'b100000);
      strobe(3'd4, 7'h40, 1);
      sb.push_back({3'd4, 4'h0, 1'b0});
      chk("cand_kept_dv", digit_valid[4], 1);
      drain();

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
